// File: rtl/deserializer_aligner.sv
// deserializer_aligner: serial-to-parallel receiver with comma-based word
// alignment. Hunts for COMMA at any bit offset, locks after LOCK_COUNT commas
// on a consistent word boundary, then emits aligned words. Lock is dropped
// after LOSS_COUNT commas seen off the boundary.
//
// Output strobe: valid_out is high for exactly one cycle when parallel_data
// carries a freshly aligned non-comma word. There is no back-pressure; the
// consumer must take the word in that cycle.
module deserializer_aligner #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_serial_in,
    output logic [WIDTH-1:0] parallel_data,
    output logic             valid_out,
    output logic             lock_out
);

    localparam int PW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(LOSS_COUNT + 1);

    localparam logic [PW-1:0] PHASE_LAST = PW'(WIDTH - 1);
    localparam logic [CW-1:0] LOCK_MAX   = CW'(LOCK_COUNT);
    localparam logic [MW-1:0] LOSS_MAX   = MW'(LOSS_COUNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sr;
    logic [PW-1:0]    phase;
    logic [PW-1:0]    phase_n;
    logic [PW-1:0]    phase_inc;
    logic [CW-1:0]    comma_cnt;
    logic [CW-1:0]    comma_cnt_n;
    logic [CW-1:0]    comma_inc;
    logic [MW-1:0]    miss_cnt;
    logic [MW-1:0]    miss_cnt_n;
    logic [MW-1:0]    miss_inc;
    logic [WIDTH-1:0] pdata_n;
    logic             valid_n;
    logic             is_comma;
    logic             boundary;

    assign is_comma  = (sr == COMMA);
    assign boundary  = (phase == '0);
    assign phase_inc = (phase == PHASE_LAST) ? '0 : phase + PW'(1);
    assign comma_inc = comma_cnt + CW'(1);
    assign miss_inc  = miss_cnt + MW'(1);
    assign lock_out  = (state == LOCKED);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    // Shift register runs in every state, so alignment can be found at any offset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= {data_serial_in, sr[WIDTH-1:1]};
        end
    end

    // Next-state, counter and output decisions from the registered word and state.
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        comma_cnt_n = comma_cnt;
        miss_cnt_n  = miss_cnt;
        pdata_n     = parallel_data;
        valid_n     = 1'b0;
        case (state)
            HUNT: begin
                pdata_n = COMMA;
                if (is_comma) begin
                    // The comma just completed defines the boundary; the next
                    // aligned word completes WIDTH cycles from now.
                    phase_n     = PW'(1);
                    comma_cnt_n = CW'(1);
                    state_n     = (LOCK_COUNT == 1) ? LOCKED : CHECK;
                end
            end
            CHECK: begin
                pdata_n = COMMA;
                phase_n = phase_inc;
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_n = comma_inc;
                        if (comma_inc == LOCK_MAX) begin
                            state_n = LOCKED;
                        end
                    end else begin
                        state_n     = HUNT;
                        comma_cnt_n = '0;
                    end
                end
            end
            LOCKED: begin
                phase_n = phase_inc;
                if (boundary) begin
                    pdata_n = sr;
                    valid_n = !is_comma;
                    if (is_comma) begin
                        miss_cnt_n = '0;
                    end
                end else if (is_comma) begin
                    // A comma off the boundary suggests the link has slipped.
                    miss_cnt_n = miss_inc;
                    if (miss_inc == LOSS_MAX) begin
                        state_n     = HUNT;
                        miss_cnt_n  = '0;
                        comma_cnt_n = '0;
                    end
                end
            end
            default: begin
                state_n = HUNT;
            end
        endcase
    end

    // Datapath and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase         <= '0;
            comma_cnt     <= '0;
            miss_cnt      <= '0;
            parallel_data <= '0;
            valid_out     <= 1'b0;
        end else begin
            phase         <= phase_n;
            comma_cnt     <= comma_cnt_n;
            miss_cnt      <= miss_cnt_n;
            parallel_data <= pdata_n;
            valid_out     <= valid_n;
        end
    end

endmodule

// File: tb/tb_deserializer_aligner.sv
// Directed bench for deserializer_aligner: an 8-bit default instance and a
// 10-bit instance with single-comma lock.
module tb_deserializer_aligner;

    logic       clk;
    logic       rst;
    logic       din;
    logic [7:0] pdata;
    logic       valid;
    logic       lock;

    logic       rst10;
    logic       din10;
    logic [9:0] pdata10;
    logic       valid10;
    logic       lock10;

    int n_cmp;
    int n_err;

    // Per-word observations from the last send8/send10 call.
    int         pulses;
    int         pulse_pos;
    logic [9:0] pulse_data;
    logic [7:0] lock_bits;
    logic [9:0] lock_bits10;

    deserializer_aligner dut (
        .clk            (clk),
        .reset          (rst),
        .data_serial_in (din),
        .parallel_data  (pdata),
        .valid_out      (valid),
        .lock_out       (lock)
    );

    deserializer_aligner #(
        .WIDTH      (10),
        .COMMA      (10'h17C),
        .LOCK_COUNT (1),
        .LOSS_COUNT (2)
    ) dut10 (
        .clk            (clk),
        .reset          (rst10),
        .data_serial_in (din10),
        .parallel_data  (pdata10),
        .valid_out      (valid10),
        .lock_out       (lock10)
    );

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din = b;
        tick();
    endtask

    task automatic send8(input logic [7:0] w);
        pulses     = 0;
        pulse_pos  = -1;
        pulse_data = '0;
        lock_bits  = '0;
        for (int i = 0; i < 8; i++) begin
            din = w[i];
            tick();
            lock_bits[i] = lock;
            if (valid) begin
                pulses++;
                pulse_pos  = i;
                pulse_data = {2'b00, pdata};
            end
        end
    endtask

    task automatic send10(input logic [9:0] w);
        pulses      = 0;
        pulse_pos   = -1;
        pulse_data  = '0;
        lock_bits10 = '0;
        for (int i = 0; i < 10; i++) begin
            din10 = w[i];
            tick();
            lock_bits10[i] = lock10;
            if (valid10) begin
                pulses++;
                pulse_pos  = i;
                pulse_data = pdata10;
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        din = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 1'($urandom_range(0, 1));
            tick();
        end
        n_cmp++;
        if (pdata !== 8'h00) begin n_err++; $display("FAIL reset_pdata: got %h want 00", pdata); end
        n_cmp++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++;
        if (lock !== 1'b0) begin n_err++; $display("FAIL reset_lock: got %b want 0", lock); end
        rst = 1'b0;
        send_bit(1'b0);
        n_cmp++;
        if (pdata !== 8'hBC) begin n_err++; $display("FAIL reset_release_pdata: got %h want bc", pdata); end
        n_cmp++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL reset_release_valid: got %b want 0", valid); end
    endtask

    task automatic test_lock_and_data();
        reset_dut();
        for (int i = 0; i < 4; i++) send8(8'hBC);
        n_cmp++;
        if (lock_bits !== 8'h00) begin n_err++; $display("FAIL lock_before_eval: got %h want 00", lock_bits); end
        send8(8'h5A);
        n_cmp++;
        if (lock_bits !== 8'hFF) begin n_err++; $display("FAIL lock_rise: got %h want ff", lock_bits); end
        n_cmp++;
        if (pulses !== 0) begin n_err++; $display("FAIL first_locked_word_pulses: got %0d want 0", pulses); end
        send8(8'hBC);
        n_cmp++;
        if (pulses !== 1 || pulse_pos !== 0 || pulse_data !== 10'h05A) begin
            n_err++; $display("FAIL data_5a: got n=%0d pos=%0d d=%h want n=1 pos=0 d=05a", pulses, pulse_pos, pulse_data);
        end
        send8(8'h3C);
        n_cmp++;
        if (pulses !== 0) begin n_err++; $display("FAIL comma_no_pulse: got %0d want 0", pulses); end
        send8(8'hBC);
        n_cmp++;
        if (pulses !== 1 || pulse_pos !== 0 || pulse_data !== 10'h03C) begin
            n_err++; $display("FAIL data_3c: got n=%0d pos=%0d d=%h want n=1 pos=0 d=03c", pulses, pulse_pos, pulse_data);
        end
    endtask

    task automatic test_misalignment();
        reset_dut();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send8(8'hBC);
        n_cmp++;
        if (lock_bits !== 8'h00) begin n_err++; $display("FAIL misalign_prelock: got %h want 00", lock_bits); end
        send8(8'hA5);
        n_cmp++;
        if (lock_bits !== 8'hFF) begin n_err++; $display("FAIL misalign_lock: got %h want ff", lock_bits); end
        send8(8'hBC);
        n_cmp++;
        if (pulses !== 1 || pulse_pos !== 0 || pulse_data !== 10'h0A5) begin
            n_err++; $display("FAIL misalign_data: got n=%0d pos=%0d d=%h want n=1 pos=0 d=0a5", pulses, pulse_pos, pulse_data);
        end
    endtask

    task automatic test_broken_lock();
        reset_dut();
        send8(8'hBC);
        send8(8'hBC);
        send8(8'h00);
        n_cmp++;
        if (lock_bits !== 8'h00) begin n_err++; $display("FAIL broken_during_00: got %h want 00", lock_bits); end
        send8(8'hBC);
        send8(8'hBC);
        n_cmp++;
        if (lock_bits !== 8'h00) begin n_err++; $display("FAIL broken_no_early_lock: got %h want 00", lock_bits); end
        send8(8'hBC);
        send8(8'hBC);
        n_cmp++;
        if (lock_bits !== 8'h00) begin n_err++; $display("FAIL broken_fourth_comma: got %h want 00", lock_bits); end
        send8(8'h11);
        n_cmp++;
        if (lock_bits !== 8'hFF) begin n_err++; $display("FAIL broken_lock_rise: got %h want ff", lock_bits); end
        send8(8'hBC);
        n_cmp++;
        if (pulses !== 1 || pulse_pos !== 0 || pulse_data !== 10'h011) begin
            n_err++; $display("FAIL broken_data_11: got n=%0d pos=%0d d=%h want n=1 pos=0 d=011", pulses, pulse_pos, pulse_data);
        end
    endtask

    task automatic test_loss_of_lock();
        reset_dut();
        for (int i = 0; i < 5; i++) send8(8'hBC);
        send_bit(1'b1);
        // Boundary now lands one bit early: slip bit plus seven comma bits.
        send8(8'hBC);
        n_cmp++;
        if (pulses !== 1 || pulse_pos !== 7 || pulse_data !== 10'h079) begin
            n_err++; $display("FAIL slip_word: got n=%0d pos=%0d d=%h want n=1 pos=7 d=079", pulses, pulse_pos, pulse_data);
        end
        n_cmp++;
        if (lock_bits !== 8'hFF) begin n_err++; $display("FAIL loss_first_miss: got %h want ff", lock_bits); end
        send8(8'hBC);
        n_cmp++;
        if (lock_bits !== 8'hFF) begin n_err++; $display("FAIL loss_still_locked: got %h want ff", lock_bits); end
        send8(8'hBC);
        n_cmp++;
        if (lock_bits !== 8'h00) begin n_err++; $display("FAIL loss_drop: got %h want 00", lock_bits); end
        n_cmp++;
        if (pulses !== 0) begin n_err++; $display("FAIL loss_no_valid: got %0d want 0", pulses); end
        send8(8'hBC);
        send8(8'hBC);
        send8(8'hBC);
        n_cmp++;
        if (lock_bits !== 8'h00) begin n_err++; $display("FAIL relock_early: got %h want 00", lock_bits); end
        send8(8'h42);
        n_cmp++;
        if (lock_bits !== 8'hFF) begin n_err++; $display("FAIL relock: got %h want ff", lock_bits); end
        send8(8'hBC);
        n_cmp++;
        if (pulses !== 1 || pulse_pos !== 0 || pulse_data !== 10'h042) begin
            n_err++; $display("FAIL relock_data: got n=%0d pos=%0d d=%h want n=1 pos=0 d=042", pulses, pulse_pos, pulse_data);
        end
    endtask

    task automatic test_reset_mid_word();
        reset_dut();
        for (int i = 0; i < 4; i++) send8(8'hBC);
        send8(8'h5A);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        n_cmp++;
        if (pdata !== 8'h5A || lock !== 1'b1) begin
            n_err++; $display("FAIL pre_reset_state: got d=%h l=%b want d=5a l=1", pdata, lock);
        end
        rst = 1'b1;
        send_bit(1'b1);
        n_cmp++;
        if (pdata !== 8'h00 || valid !== 1'b0 || lock !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: got d=%h v=%b l=%b want d=00 v=0 l=0", pdata, valid, lock);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send8(8'hBC);
        send8(8'h3C);
        n_cmp++;
        if (lock_bits !== 8'hFF) begin n_err++; $display("FAIL post_reset_lock: got %h want ff", lock_bits); end
        send8(8'hBC);
        n_cmp++;
        if (pulses !== 1 || pulse_pos !== 0 || pulse_data !== 10'h03C) begin
            n_err++; $display("FAIL post_reset_data: got n=%0d pos=%0d d=%h want n=1 pos=0 d=03c", pulses, pulse_pos, pulse_data);
        end
    endtask

    task automatic test_width10();
        rst10 = 1'b1;
        din10 = 1'b0;
        tick();
        n_cmp++;
        if (pdata10 !== 10'h000 || valid10 !== 1'b0 || lock10 !== 1'b0) begin
            n_err++; $display("FAIL w10_reset: got d=%h v=%b l=%b want d=000 v=0 l=0", pdata10, valid10, lock10);
        end
        rst10 = 1'b0;
        send10(10'h17C);
        n_cmp++;
        if (lock_bits10 !== 10'h000) begin n_err++; $display("FAIL w10_prelock: got %h want 000", lock_bits10); end
        send10(10'h2A5);
        n_cmp++;
        if (lock_bits10 !== 10'h3FF) begin n_err++; $display("FAIL w10_lock: got %h want 3ff", lock_bits10); end
        n_cmp++;
        if (pulses !== 0) begin n_err++; $display("FAIL w10_no_early_pulse: got %0d want 0", pulses); end
        send10(10'h17C);
        n_cmp++;
        if (pulses !== 1 || pulse_pos !== 0 || pulse_data !== 10'h2A5) begin
            n_err++; $display("FAIL w10_data: got n=%0d pos=%0d d=%h want n=1 pos=0 d=2a5", pulses, pulse_pos, pulse_data);
        end
    endtask

    // Test sequence and final report.
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        din   = 1'b0;
        rst10 = 1'b1;
        din10 = 1'b0;
        test_reset();
        test_lock_and_data();
        test_misalignment();
        test_broken_lock();
        test_loss_of_lock();
        test_reset_mid_word();
        test_width10();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
